// File: rtl/addsub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder built from two half-adder stages.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;
    logic g1;
    logic g2;

    assign p    = a ^ b;
    assign g1   = a & b;
    assign s    = p ^ cin;
    assign g2   = p & cin;
    assign cout = g1 | g2;

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract: BPC bits per clock, held valid/ready output.
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int STEPS = WIDTH / BPC;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (WIDTH < 2) begin : g_chk_w
        $error("serial_addsub: WIDTH must be >= 2");
    end
    if (WIDTH % BPC != 0) begin : g_chk_bpc
        $error("serial_addsub: BPC must divide WIDTH");
    end

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [BPC-1:0]   sum;
    logic [BPC:0]     c;
    logic             accept;
    logic             last;

    assign c[0] = carry;

    for (genvar i = 0; i < BPC; i++) begin : g_chain
        fa_cell u_fa (
            .a    (a_sh[i]),
            .b    (b_sh[i]),
            .cin  (c[i]),
            .s    (sum[i]),
            .cout (c[i+1])
        );
    end

    // Sum digits enter at the MSB end so the LSB digit lands last at bit 0.
    if (BPC == WIDTH) begin : g_res_full
        assign res_nxt = sum;
    end else begin : g_res_part
        assign res_nxt = {sum, res_sh[WIDTH-1:BPC]};
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign last      = (cnt == CW'(STEPS - 1));
    assign result    = res_sh;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN:  if (last) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            if (state == IDLE && accept) begin
                a_sh  <= a;
                b_sh  <= b ^ {WIDTH{sub == MODE_SUB}};
                carry <= (sub == MODE_SUB);
                cnt   <= '0;
            end else if (state == RUN) begin
                a_sh   <= a_sh >> BPC;
                b_sh   <= b_sh >> BPC;
                res_sh <= res_nxt;
                carry  <= c[BPC];
                cnt    <= cnt + 1'b1;
                if (last) begin
                    carry_out <= c[BPC];
                    overflow  <= c[BPC-1] ^ c[BPC];
                    zero      <= (res_nxt == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub at WIDTH=8/BPC=1 and WIDTH=16/BPC=4.
module tb_serial_addsub;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic       iv8 = 1'b0, ir8, ov8, or8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, r8;
    logic       s8 = 1'b0, co8, of8, z8;

    logic        iv16 = 1'b0, ir16, ov16, or16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0, r16;
    logic        s16 = 1'b0, co16, of16, z16;

    serial_addsub #(.WIDTH(8), .BPC(1)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .sub(s8),
        .out_valid(ov8), .out_ready(or8),
        .result(r8), .carry_out(co8),
        .overflow(of8), .zero(z8)
    );

    serial_addsub #(.WIDTH(16), .BPC(4)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .sub(s16),
        .out_valid(ov16), .out_ready(or16),
        .result(r16), .carry_out(co16),
        .overflow(of16), .zero(z16)
    );

    task automatic start8(input logic [7:0] a, input logic [7:0] b,
                          input logic s);
        @(negedge clk);
        a8 = a; b8 = b; s8 = s; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
    endtask

    task automatic wait8(output int lat);
        lat = 0;
        while (!ov8 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take8();
        @(negedge clk);
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
    endtask

    task automatic op8(input string nm,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic [7:0] er,
                       input logic eco, input logic eof,
                       input logic ez);
        int lat;
        start8(a, b, s);
        wait8(lat);
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL %s latency: got %0d want 8", nm, lat);
        end
        checks++;
        if ({r8, co8, of8, z8} !== {er, eco, eof, ez}) begin
            errors++;
            $display("FAIL %s: got r=%h c=%b v=%b z=%b want r=%h c=%b v=%b z=%b",
                     nm, r8, co8, of8, z8, er, eco, eof, ez);
        end
        take8();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({ov8, r8, co8, of8, z8, ir8} !== {1'b0, 8'h00, 4'b0001}) begin
            errors++;
            $display("FAIL reset8: ov=%b r=%h c=%b v=%b z=%b ir=%b want 0 00 0 0 0 1",
                     ov8, r8, co8, of8, z8, ir8);
        end
        checks++;
        if ({ov16, r16, ir16} !== {1'b0, 16'h0000, 1'b1}) begin
            errors++;
            $display("FAIL reset16: ov=%b r=%h ir=%b want 0 0000 1",
                     ov16, r16, ir16);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        op8("add_35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0);
        op8("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_sub();
        op8("sub_10_20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
        op8("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        int lat;
        int bad = 0;
        start8(8'h21, 8'h13, 1'b0);
        wait8(lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a8 = 8'hAA; b8 = 8'h55; s8 = 1'b1; iv8 = (i % 2 == 0);
            @(posedge clk); #1;
            if ({ov8, ir8, r8, co8, of8, z8} !== {2'b10, 8'h34, 3'b000})
                bad++;
        end
        iv8 = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure hold: %0d bad cycles, last ov=%b ir=%b r=%h want 1 0 34",
                     bad, ov8, ir8, r8);
        end
        take8();
        checks++;
        if ({ov8, ir8} !== 2'b01) begin
            errors++;
            $display("FAIL backpressure release: ov=%b ir=%b want 0 1",
                     ov8, ir8);
        end
    endtask

    task automatic test_reset_mid_run();
        start8(8'h11, 8'h22, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ov8, r8, ir8} !== {1'b0, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL midrun reset: ov=%b r=%h ir=%b want 0 00 1",
                     ov8, r8, ir8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        op8("after_reset", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic op16(input string nm,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [15:0] er,
                        input logic eco, input logic ez);
        int lat = 0;
        @(negedge clk);
        a16 = a; b16 = b; s16 = s; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        while (!ov16 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL %s latency: got %0d want 4", nm, lat);
        end
        checks++;
        if ({r16, co16, z16} !== {er, eco, ez}) begin
            errors++;
            $display("FAIL %s: got r=%h c=%b z=%b want r=%h c=%b z=%b",
                     nm, r16, co16, z16, er, eco, ez);
        end
        @(negedge clk);
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;
    endtask

    task automatic test_wide();
        op16("w_add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1);
        op16("w_sub_1234", 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b1);
        op16("w_add_1234_4321", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_reset_mid_run();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
